magnitude_arbiter: RTL and testbench

Round-robin arbiter that time-shares one pipelined magnitude_finder between NUM_REQ requesters, e.g. per-channel I/Q streams in the DPM path.
- Accepts at most one (x, y) pair per clock.
- Drives the finder's input port.
- Tags each issue with the requester ID through a delay line matched to the finder's latency.
- Returns each magnitude with its ID and flags any valid/tag misalignment.

---
 rtl/magnitude_arbiter.sv | 144 ++++++++++++++
 tb/tb_magnitude_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/magnitude_arbiter.sv
// Round-robin front end that time-shares one pipelined magnitude finder between
// NUM_REQ requesters, tagging each issue with its requester ID to route results back.
module magnitude_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAG_WIDTH  = 33,
  parameter int LATENCY    = 22,
  parameter int ID_WIDTH   = $clog2(NUM_REQ),
  localparam int IF_WIDTH  = ID_WIDTH + $clog2(LATENCY + 2)
) (
  input  logic                          i_clk,
  input  logic                          i_resetn,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] iS_req_x,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] iS_req_y,
  output logic                          o_mag_valid,
  output logic [DATA_WIDTH-1:0]         oS_mag_x,
  output logic [DATA_WIDTH-1:0]         oS_mag_y,
  input  logic                          i_mag_valid,
  input  logic [MAG_WIDTH-1:0]          i_mag_result,
  output logic                          o_res_valid,
  output logic [ID_WIDTH-1:0]           o_res_id,
  output logic [MAG_WIDTH-1:0]          o_res_mag,
  output logic [IF_WIDTH-1:0]           o_in_flight,
  output logic                          o_align_err
);

  logic [ID_WIDTH-1:0]   ptr_q;
  logic [ID_WIDTH-1:0]   win_id;
  logic [ID_WIDTH:0]     scan_idx;
  logic                  found;
  logic                  transfer;

  logic                  mag_valid_q;
  logic [DATA_WIDTH-1:0] x_q, y_q;
  logic [ID_WIDTH-1:0]   issue_id_q;

  logic                  tag_v_q  [LATENCY];
  logic [ID_WIDTH-1:0]   tag_id_q [LATENCY];
  logic                  tail_v;
  logic [ID_WIDTH-1:0]   tail_id;

  logic                  res_valid_q;
  logic [ID_WIDTH-1:0]   res_id_q;
  logic [MAG_WIDTH-1:0]  res_mag_q;
  logic [IF_WIDTH-1:0]   in_flight_q;
  logic                  align_err_q;

  // Scan from the pointer, wrapping; first pending requester wins.
  always_comb begin
    found    = 1'b0;
    win_id   = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, ptr_q} + (ID_WIDTH + 1)'(i);
      if (scan_idx >= (ID_WIDTH + 1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (ID_WIDTH + 1)'(NUM_REQ);
      end
      if (!found && i_req_valid[scan_idx[ID_WIDTH-1:0]]) begin
        found  = 1'b1;
        win_id = scan_idx[ID_WIDTH-1:0];
      end
    end
  end

  // Gated by reset so ready reads 0 while the block is held in reset.
  assign o_req_ready = (found && i_resetn) ? (NUM_REQ'(1) << win_id) : '0;
  assign transfer    = |o_req_ready;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      ptr_q       <= '0;
      mag_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      issue_id_q  <= '0;
    end else begin
      mag_valid_q <= transfer;
      if (transfer) begin
        ptr_q      <= (win_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
        x_q        <= iS_req_x[win_id*DATA_WIDTH +: DATA_WIDTH];
        y_q        <= iS_req_y[win_id*DATA_WIDTH +: DATA_WIDTH];
        issue_id_q <= win_id;
      end
    end
  end

  // Stage 0 samples the registered issue, so the tail lines up with the finder output.
  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_tag
      always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
          tag_v_q[gi]  <= 1'b0;
          tag_id_q[gi] <= '0;
        end else if (gi == 0) begin
          tag_v_q[gi]  <= mag_valid_q;
          tag_id_q[gi] <= issue_id_q;
        end else begin
          tag_v_q[gi]  <= tag_v_q[gi-1];
          tag_id_q[gi] <= tag_id_q[gi-1];
        end
      end
    end
  endgenerate

  assign tail_v  = tag_v_q[LATENCY-1];
  assign tail_id = tag_id_q[LATENCY-1];

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_mag_q   <= '0;
      in_flight_q <= '0;
      align_err_q <= 1'b0;
    end else begin
      res_valid_q <= tail_v & i_mag_valid;
      if (tail_v && i_mag_valid) begin
        res_id_q  <= tail_id;
        res_mag_q <= i_mag_result;
      end
      if (tail_v ^ i_mag_valid) begin
        align_err_q <= 1'b1;
      end
      case ({transfer, tail_v})
        2'b10:   in_flight_q <= in_flight_q + 1'b1;
        2'b01:   in_flight_q <= in_flight_q - 1'b1;
        default: in_flight_q <= in_flight_q;
      endcase
    end
  end

  assign o_mag_valid = mag_valid_q;
  assign oS_mag_x    = x_q;
  assign oS_mag_y    = y_q;
  assign o_res_valid = res_valid_q;
  assign o_res_id    = res_id_q;
  assign o_res_mag   = res_mag_q;
  assign o_in_flight = in_flight_q;
  assign o_align_err = align_err_q;

endmodule

// File: tb/tb_magnitude_arbiter.sv
// Directed bench for magnitude_arbiter with a behavioural pipelined finder that can
// be made to answer one clock late.
module tb_magnitude_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int MW = 33;
  localparam int LAT = 22;
  localparam int IW = 2;
  localparam int FW = IW + $clog2(LAT + 2);

  logic           clk = 1'b0;
  logic           resetn = 1'b1;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [NR*DW-1:0] req_x, req_y;
  logic           mag_valid;
  logic [DW-1:0]  mag_x, mag_y;
  logic           fin_valid;
  logic [MW-1:0]  fin_result;
  logic           res_valid;
  logic [IW-1:0]  res_id;
  logic [MW-1:0]  res_mag;
  logic [FW-1:0]  in_flight;
  logic           align_err;
  logic           late;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  magnitude_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAG_WIDTH(MW), .LATENCY(LAT)) dut (
    .i_clk(clk), .i_resetn(resetn),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .iS_req_x(req_x), .iS_req_y(req_y),
    .o_mag_valid(mag_valid), .oS_mag_x(mag_x), .oS_mag_y(mag_y),
    .i_mag_valid(fin_valid), .i_mag_result(fin_result),
    .o_res_valid(res_valid), .o_res_id(res_id), .o_res_mag(res_mag),
    .o_in_flight(in_flight), .o_align_err(align_err)
  );

  // Behavioural finder: output valid LAT clocks after its input valid (LAT+1 when late).
  function automatic logic [MW-1:0] mag_of(input logic [DW-1:0] x, input logic [DW-1:0] y);
    longint xx, yy;
    real r;
    xx = longint'($signed(x));
    yy = longint'($signed(y));
    r  = $sqrt(real'(xx * xx + yy * yy));
    return MW'(longint'(r));
  endfunction

  logic          fv [LAT+1];
  logic [MW-1:0] fm [LAT+1];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k <= LAT; k++) begin
        fv[k] <= 1'b0;
        fm[k] <= '0;
      end
    end else begin
      fv[0] <= mag_valid;
      fm[0] <= mag_of(mag_x, mag_y);
      for (int k = 1; k <= LAT; k++) begin
        fv[k] <= fv[k-1];
        fm[k] <= fm[k-1];
      end
    end
  end

  assign fin_valid  = late ? fv[LAT]   : fv[LAT-1];
  assign fin_result = late ? fm[LAT]   : fm[LAT-1];

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input int x, input int y);
    req_x[k*DW +: DW] = x;
    req_y[k*DW +: DW] = y;
  endtask

  int res_count;

  initial begin
    req_valid = '0;
    late      = 1'b0;
    req_x     = '0;
    req_y     = '0;
    for (int k = 0; k < NR; k++) set_data(k, 3000 * (k + 1), 4000 * (k + 1));
    set_data(2, -600000, -800000);

    // Reset state, with requests pending to show ready is suppressed.
    #1 resetn = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_mag_valid", mag_valid, 0);
    check("rst_in_flight", in_flight, 0);
    check("rst_align_err", align_err, 0);
    check("rst_res_valid", res_valid, 0);
    req_valid = '0;
    tick(); tick();
    resetn = 1'b1;
    tick();

    // Single request from requester 2.
    req_valid = 4'b0100;
    #1 check("t1_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    check("t1_mag_valid", mag_valid, 1);
    check("t1_mag_x", $signed(mag_x), -600000);
    check("t1_mag_y", $signed(mag_y), -800000);
    check("t1_in_flight_first", in_flight, 1);
    for (int c = 2; c <= 23; c++) begin
      tick();
      check("t1_in_flight_hold", in_flight, 1);
      check("t1_no_early_res", res_valid, 0);
    end
    tick();
    check("t1_res_valid", res_valid, 1);
    check("t1_res_id", res_id, 2);
    check("t1_res_mag", res_mag, 1000000);
    check("t1_in_flight_done", in_flight, 0);
    tick();
    check("t1_res_strobe_one", res_valid, 0);

    // Reset the pointer, then all four requesters continuously for 12 cycles.
    set_data(2, 9000, 12000);
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      #1 check("t2_rotation", req_ready, longint'(4'b0001 << (i % 4)));
      tick();
    end
    req_valid = '0;
    check("t2_in_flight_12", in_flight, 12);
    repeat (11) tick();
    check("t2_no_early_res", res_valid, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("t2_res_valid", res_valid, 1);
      check("t2_res_id", res_id, i % 4);
      check("t2_res_mag", res_mag, 5000 * (i % 4 + 1));
    end
    tick();
    check("t2_res_end", res_valid, 0);
    check("t2_in_flight_end", in_flight, 0);

    // Fairness: requester 3 arrives once while the pointer is at 2.
    req_valid = 4'b0010;
    #1 check("t3_grant_1a", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1010;
    #1 check("t3_grant_3", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0010;
    #1 check("t3_grant_1b", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    repeat (30) tick();
    check("t3_in_flight_drain", in_flight, 0);
    check("t3_no_align_err", align_err, 0);

    // Misalignment: finder answers one clock late.
    late = 1'b1;
    req_valid = 4'b0001;
    #1 check("t4_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    repeat (22) tick();
    check("t4_err_before", align_err, 0);
    tick();
    check("t4_err_set", align_err, 1);
    check("t4_no_res_a", res_valid, 0);
    tick();
    check("t4_no_res_b", res_valid, 0);
    repeat (10) tick();
    check("t4_err_sticky", align_err, 1);
    check("t4_in_flight", in_flight, 0);
    late = 1'b0;

    // Reset mid-stream with 10 issues in flight.
    req_valid = 4'b0001;
    repeat (10) tick();
    check("t5_in_flight_10", in_flight, 10);
    #2 resetn = 1'b0;
    #1;
    check("t5_async_ready", req_ready, 0);
    check("t5_async_mag_valid", mag_valid, 0);
    check("t5_async_in_flight", in_flight, 0);
    check("t5_async_err", align_err, 0);
    check("t5_async_mag_x", mag_x, 0);
    tick(); tick(); tick();
    check("t5_held_res_valid", res_valid, 0);
    resetn = 1'b1;
    req_valid = 4'b1111;
    #1 check("t5_ptr_zero", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    res_count = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (res_valid) res_count++;
    end
    check("t5_single_result", res_count, 1);
    check("t5_res_id", res_id, 0);
    check("t5_res_mag", res_mag, 5000);
    check("t5_in_flight_end", in_flight, 0);
    check("t5_no_err", align_err, 0);

    // Idle hold.
    for (int c = 0; c < 5; c++) begin
      repeat (10) tick();
      check("t6_ready", req_ready, 0);
      check("t6_mag_valid", mag_valid, 0);
      check("t6_hold_x", $signed(mag_x), 3000);
      check("t6_hold_y", $signed(mag_y), 4000);
      check("t6_in_flight", in_flight, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
